// File: rtl/sb_pkg.sv
// Shared definitions for the system bus (sb_*) arbitration logic: the
// arbiter state encoding, default watchdog limits and bus geometry.
package sb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BEGIN,
        BUSY,
        ABORT
    } sb_state_e;

    // Default watchdog limits, in bus clock cycles
    localparam int SB_BEGIN_TIMEOUT = 15;
    localparam int SB_XFER_TIMEOUT  = 1023;

    // Bus geometry shared by masters and slaves
    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_BURST_SIZE = 8;

endpackage

// File: rtl/sb_rr_picker.sv
// Combinational round-robin picker. The search starts one position above
// the previous winner and wraps, so the previous winner is considered last.
// Kept generic so the interrupt arbiter can reuse it.
module sb_rr_picker
    import sb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int IW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IW-1:0]          last_winner,
    output logic                   valid,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IW-1:0]          index
);

    // Walk the request vector from last_winner+1 upward with wrap-around; first hit wins
    always_comb begin : search
        int pos;
        pos    = 0;
        valid  = 1'b0;
        onehot = '0;
        index  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            pos = int'(last_winner) + i;
            if (pos >= NUM_MASTERS) begin
                pos = pos - NUM_MASTERS;
            end
            if (!valid && request[pos[IW-1:0]]) begin
                valid              = 1'b1;
                index              = pos[IW-1:0];
                onehot[pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_arbiter.sv
// Round-robin arbiter for the shared system bus. Grants the bus with a
// one-cycle pulse, follows the transaction until end_transaction, and runs
// two watchdogs: one revokes a grant that is never used, the other aborts a
// transaction that stalls without the slave signalling busy.
module sb_arbiter
    import sb_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int BEGIN_TIMEOUT = SB_BEGIN_TIMEOUT,
    parameter int XFER_TIMEOUT  = SB_XFER_TIMEOUT,
    localparam int IW = $clog2(NUM_MASTERS)
) (
    input  logic                   sb_clock_i,
    input  logic                   sb_reset_n_i,
    input  logic [NUM_MASTERS-1:0] sb_request_i,
    output logic [NUM_MASTERS-1:0] sb_grant_o,
    input  logic                   sb_begin_transaction_i,
    input  logic                   sb_end_transaction_i,
    input  logic                   sb_data_valid_i,
    input  logic                   sb_busy_i,
    output logic                   sb_end_transaction_o,
    output logic                   sb_error_o,
    output logic [IW-1:0]          bus_owner_o,
    output logic                   bus_active_o
);

    localparam int BW = $clog2(BEGIN_TIMEOUT + 1);
    localparam int SW = $clog2(XFER_TIMEOUT + 1);

    sb_state_e              state;
    sb_state_e              next_state;
    logic [BW-1:0]          begin_cnt;
    logic [BW-1:0]          begin_cnt_next;
    logic [SW-1:0]          stall_cnt;
    logic [SW-1:0]          stall_cnt_next;
    logic [IW-1:0]          owner;
    logic [NUM_MASTERS-1:0] grant;
    logic                   abort_end;
    logic                   abort_error;

    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_index;

    // The owner register doubles as the round-robin pointer (last winner)
    sb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .request     (sb_request_i),
        .last_winner (owner),
        .valid       (pick_valid),
        .onehot      (pick_onehot),
        .index       (pick_index)
    );

    // Next-state and watchdog counter logic; a counter reaching its limit triggers the exit
    always_comb begin
        next_state     = state;
        begin_cnt_next = begin_cnt;
        stall_cnt_next = stall_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                next_state     = WAIT_BEGIN;
                begin_cnt_next = '0;
            end
            WAIT_BEGIN: begin
                if (sb_begin_transaction_i) begin
                    next_state     = BUSY;
                    stall_cnt_next = '0;
                end else begin
                    if (begin_cnt != BW'(BEGIN_TIMEOUT)) begin
                        begin_cnt_next = begin_cnt + 1'b1;
                    end
                    if (begin_cnt_next == BW'(BEGIN_TIMEOUT)) begin
                        next_state = IDLE;
                    end
                end
            end
            BUSY: begin
                if (sb_end_transaction_i) begin
                    next_state = IDLE;
                end else begin
                    if (sb_data_valid_i) begin
                        stall_cnt_next = '0;
                    end else if (!sb_busy_i && stall_cnt != SW'(XFER_TIMEOUT)) begin
                        stall_cnt_next = stall_cnt + 1'b1;
                    end
                    if (stall_cnt_next == SW'(XFER_TIMEOUT)) begin
                        next_state = ABORT;
                    end
                end
            end
            ABORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset drops everything without signalling the bus
    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            state       <= IDLE;
            begin_cnt   <= '0;
            stall_cnt   <= '0;
            owner       <= '0;
            grant       <= '0;
            abort_end   <= 1'b0;
            abort_error <= 1'b0;
        end else begin
            state       <= next_state;
            begin_cnt   <= begin_cnt_next;
            stall_cnt   <= stall_cnt_next;
            grant       <= (state == IDLE && pick_valid) ? pick_onehot : '0;
            abort_end   <= (next_state == ABORT);
            abort_error <= (next_state == ABORT);
            if (state == IDLE && pick_valid) begin
                owner <= pick_index;
            end
        end
    end

    assign sb_grant_o           = grant;
    assign bus_owner_o          = owner;
    assign sb_end_transaction_o = abort_end;
    assign sb_error_o           = abort_error;
    assign bus_active_o         = (state != IDLE);

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed testbench for sb_arbiter: reset, single grant, round-robin order,
// begin timeout, stall watchdog, busy hold, data_valid restart, end/timeout
// collision and reset in the middle of a transaction.
module tb_sb_arbiter;

    logic       sb_clock = 1'b0;
    logic       sb_reset_n = 1'b0;
    logic [3:0] sb_request = 4'b0000;
    logic [3:0] sb_grant;
    logic       begin_t = 1'b0;
    logic       end_t = 1'b0;
    logic       data_valid = 1'b0;
    logic       busy = 1'b0;
    logic       end_o;
    logic       error_o;
    logic [1:0] bus_owner;
    logic       bus_active;

    int tests_run = 0;
    int tests_failed = 0;

    sb_arbiter #(
        .NUM_MASTERS   (4),
        .BEGIN_TIMEOUT (15),
        .XFER_TIMEOUT  (1023)
    ) dut (
        .sb_clock_i             (sb_clock),
        .sb_reset_n_i           (sb_reset_n),
        .sb_request_i           (sb_request),
        .sb_grant_o             (sb_grant),
        .sb_begin_transaction_i (begin_t),
        .sb_end_transaction_i   (end_t),
        .sb_data_valid_i        (data_valid),
        .sb_busy_i              (busy),
        .sb_end_transaction_o   (end_o),
        .sb_error_o             (error_o),
        .bus_owner_o            (bus_owner),
        .bus_active_o           (bus_active)
    );

    // Free-running bus clock
    always #5 sb_clock = ~sb_clock;

    // Hard stop in case the DUT never produces an awaited event
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: time %0t reached, limit 1000000", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // One cycle of synchronous reset with all bus inputs idle
    task automatic do_reset();
        @(negedge sb_clock);
        sb_reset_n = 1'b0;
        sb_request = 4'b0000;
        begin_t = 1'b0;
        end_t = 1'b0;
        data_valid = 1'b0;
        busy = 1'b0;
        @(negedge sb_clock);
        sb_reset_n = 1'b1;
    endtask

    // Wait (bounded) for a grant pulse; returns at the negedge where it is visible
    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            @(negedge sb_clock);
            if (sb_grant !== 4'b0000) break;
        end
    endtask

    // From the GRANT cycle: begin in WAIT_BEGIN, return in the first BUSY cycle
    task automatic start_xact();
        @(negedge sb_clock);
        begin_t = 1'b1;
        @(negedge sb_clock);
        begin_t = 1'b0;
    endtask

    // From the GRANT cycle: full begin/end, return in the following IDLE cycle
    task automatic complete_xact();
        start_xact();
        end_t = 1'b1;
        @(negedge sb_clock);
        end_t = 1'b0;
    endtask

    // Run n BUSY cycles with given busy/data_valid; flags any abort or early exit
    task automatic run_busy(input int n, input logic b, input logic v, output bit bad);
        bad = 1'b0;
        busy = b;
        data_valid = v;
        for (int i = 0; i < n; i++) begin
            @(negedge sb_clock);
            if (end_o !== 1'b0 || error_o !== 1'b0 || bus_active !== 1'b1) bad = 1'b1;
        end
        busy = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (sb_grant !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected 0000", sb_grant); end
        tests_run++;
        if (bus_owner !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_owner: got %0d expected 0", bus_owner); end
        tests_run++;
        if (bus_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_active: got %b expected 0", bus_active); end
        tests_run++;
        if (end_o !== 1'b0 || error_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_end_error: got %b%b expected 00", end_o, error_o); end
    endtask

    task automatic test_single();
        do_reset();
        sb_request = 4'b0010;
        @(negedge sb_clock);
        tests_run++;
        if (sb_grant !== 4'b0010) begin tests_failed++; $display("[TB] FAIL single_grant: got %b expected 0010", sb_grant); end
        tests_run++;
        if (bus_owner !== 2'd1) begin tests_failed++; $display("[TB] FAIL single_owner: got %0d expected 1", bus_owner); end
        sb_request = 4'b0000;
        @(negedge sb_clock);
        tests_run++;
        if (sb_grant !== 4'b0000 || bus_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_pulse: got grant %b active %b expected 0000 1", sb_grant, bus_active); end
        begin_t = 1'b1;
        @(negedge sb_clock);
        begin_t = 1'b0;
        tests_run++;
        if (bus_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy: got active %b expected 1", bus_active); end
        end_t = 1'b1;
        @(negedge sb_clock);
        end_t = 1'b0;
        tests_run++;
        if (bus_active !== 1'b0 || error_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_end: got active %b error %b expected 0 0", bus_active, error_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [3:0] expected;
        order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        sb_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant();
            expected = 4'b0001 << order[k];
            tests_run++;
            if (sb_grant !== expected || bus_owner !== order[k]) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant_%0d: got grant %b owner %0d expected %b owner %0d", k, sb_grant, bus_owner, expected, order[k]);
            end
            complete_xact();
        end
        sb_request = 4'b0000;
    endtask

    task automatic test_begin_timeout();
        bit active_drop;
        bit err_seen;
        active_drop = 1'b0;
        err_seen = 1'b0;
        do_reset();
        sb_request = 4'b0010;
        wait_grant();
        sb_request = 4'b0000;
        complete_xact();
        sb_request = 4'b0101;
        wait_grant();
        tests_run++;
        if (sb_grant !== 4'b0100) begin tests_failed++; $display("[TB] FAIL bto_first_grant: got %b expected 0100", sb_grant); end
        for (int i = 0; i < 15; i++) begin
            @(negedge sb_clock);
            if (bus_active !== 1'b1) active_drop = 1'b1;
            if (error_o !== 1'b0 || end_o !== 1'b0) err_seen = 1'b1;
        end
        tests_run++;
        if (active_drop) begin tests_failed++; $display("[TB] FAIL bto_wait_len: got early IDLE expected 15 WAIT_BEGIN cycles"); end
        @(negedge sb_clock);
        tests_run++;
        if (bus_active !== 1'b0 || error_o !== 1'b0 || err_seen) begin tests_failed++; $display("[TB] FAIL bto_idle: got active %b error %b err_seen %b expected 0 0 0", bus_active, error_o, err_seen); end
        @(negedge sb_clock);
        tests_run++;
        if (sb_grant !== 4'b0001 || bus_owner !== 2'd0) begin tests_failed++; $display("[TB] FAIL bto_next_grant: got %b owner %0d expected 0001 owner 0", sb_grant, bus_owner); end
        sb_request = 4'b0000;
        wait_grant();
    endtask

    task automatic test_watchdog();
        bit bad;
        do_reset();
        sb_request = 4'b0001;
        wait_grant();
        sb_request = 4'b0000;
        start_xact();
        run_busy(1022, 1'b0, 1'b0, bad);
        tests_run++;
        if (bad) begin tests_failed++; $display("[TB] FAIL wd_early: got abort before 1023 stalls expected none"); end
        @(negedge sb_clock);
        tests_run++;
        if (end_o !== 1'b1 || error_o !== 1'b1 || bus_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL wd_abort: got end %b error %b active %b expected 1 1 1", end_o, error_o, bus_active); end
        @(negedge sb_clock);
        tests_run++;
        if (end_o !== 1'b0 || error_o !== 1'b0 || bus_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL wd_after: got end %b error %b active %b expected 0 0 0", end_o, error_o, bus_active); end
    endtask

    task automatic test_busy_hold();
        bit bad_a;
        bit bad_b;
        bit bad_c;
        do_reset();
        sb_request = 4'b0001;
        wait_grant();
        sb_request = 4'b0000;
        start_xact();
        run_busy(1000, 1'b0, 1'b0, bad_a);
        run_busy(1500, 1'b1, 1'b0, bad_b);
        run_busy(22, 1'b0, 1'b0, bad_c);
        tests_run++;
        if (bad_a || bad_b || bad_c) begin tests_failed++; $display("[TB] FAIL busy_no_abort: got abort flags %b%b%b expected 000", bad_a, bad_b, bad_c); end
        @(negedge sb_clock);
        tests_run++;
        if (error_o !== 1'b1 || end_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_held_count: got end %b error %b expected 1 1", end_o, error_o); end
        @(negedge sb_clock);
    endtask

    task automatic test_data_valid();
        bit bad_a;
        bit bad_b;
        bit bad_c;
        do_reset();
        sb_request = 4'b0001;
        wait_grant();
        sb_request = 4'b0000;
        start_xact();
        run_busy(1000, 1'b0, 1'b0, bad_a);
        run_busy(1, 1'b0, 1'b1, bad_b);
        run_busy(1022, 1'b0, 1'b0, bad_c);
        tests_run++;
        if (bad_a || bad_b || bad_c) begin tests_failed++; $display("[TB] FAIL dv_restart: got abort flags %b%b%b expected 000", bad_a, bad_b, bad_c); end
        @(negedge sb_clock);
        tests_run++;
        if (error_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL dv_abort: got error %b expected 1", error_o); end
        @(negedge sb_clock);
    endtask

    task automatic test_simultaneous();
        bit bad;
        do_reset();
        sb_request = 4'b0001;
        wait_grant();
        sb_request = 4'b0000;
        start_xact();
        run_busy(1022, 1'b0, 1'b0, bad);
        end_t = 1'b1;
        @(negedge sb_clock);
        end_t = 1'b0;
        tests_run++;
        if (bad || bus_active !== 1'b0 || error_o !== 1'b0 || end_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL simul_end: got active %b error %b end %b expected 0 0 0", bus_active, error_o, end_o); end
        @(negedge sb_clock);
        tests_run++;
        if (error_o !== 1'b0 || end_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL simul_after: got error %b end %b expected 0 0", error_o, end_o); end
    endtask

    task automatic test_reset_mid_busy();
        bit bad;
        do_reset();
        sb_request = 4'b0100;
        wait_grant();
        sb_request = 4'b0000;
        tests_run++;
        if (bus_owner !== 2'd2) begin tests_failed++; $display("[TB] FAIL rmb_owner: got %0d expected 2", bus_owner); end
        start_xact();
        run_busy(10, 1'b0, 1'b0, bad);
        sb_reset_n = 1'b0;
        @(negedge sb_clock);
        sb_reset_n = 1'b1;
        tests_run++;
        if (sb_grant !== 4'b0000 || bus_owner !== 2'd0 || bus_active !== 1'b0 || end_o !== 1'b0 || error_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rmb_outputs: got grant %b owner %0d active %b end %b error %b expected 0000 0 0 0 0", sb_grant, bus_owner, bus_active, end_o, error_o);
        end
        sb_request = 4'b0001;
        @(negedge sb_clock);
        sb_request = 4'b0000;
        tests_run++;
        if (sb_grant !== 4'b0001 || bus_owner !== 2'd0) begin tests_failed++; $display("[TB] FAIL rmb_regrant: got %b owner %0d expected 0001 owner 0", sb_grant, bus_owner); end
        @(negedge sb_clock);
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_begin_timeout();
        test_watchdog();
        test_busy_hold();
        test_data_valid();
        test_simultaneous();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
